// File: rtl/gray_frame_capture_pkg.sv
// Shared types and default sizes for the gray frame capture sink.
package gray_frame_capture_pkg;

   localparam int DATAWIDTH_DEF = 8;
   localparam int ADDRWIDTH_DEF = 18;
   localparam int NPIXELS_DEF   = 262144;
   localparam int SUMWIDTH_DEF  = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

endpackage

// File: rtl/gray_frame_capture_if.sv
// Pixel stream in and gray RAM write port out, bundled as one bus.
interface gray_frame_capture_if
   import gray_frame_capture_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEF,
   parameter int ADDRWIDTH = ADDRWIDTH_DEF
);

   logic                 start;
   logic [DATAWIDTH-1:0] Gray;
   logic                 Done_one;
   logic                 Done_full;
   logic                 wea;
   logic [ADDRWIDTH-1:0] addra;
   logic [DATAWIDTH-1:0] dina;

   modport master (
      output start, Gray, Done_one, Done_full,
      input  wea, addra, dina
   );

   modport slave (
      input  start, Gray, Done_one, Done_full,
      output wea, addra, dina
   );

endinterface

// File: rtl/gray_frame_capture.sv
// Captures a raster gray frame into RAM, counting pixels and
// summing them, with short-frame and overrun flags.
module gray_frame_capture
   import gray_frame_capture_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEF,
   parameter int ADDRWIDTH = ADDRWIDTH_DEF,
   parameter int NPIXELS   = NPIXELS_DEF,
   parameter int SUMWIDTH  = SUMWIDTH_DEF
) (
   input  logic                 CLK,
   input  logic                 RST,
   gray_frame_capture_if.slave  bus,
   output logic                 busy,
   output logic                 frame_done,
   output logic [ADDRWIDTH:0]   pix_count,
   output logic [SUMWIDTH-1:0]  checksum,
   output logic                 short_err,
   output logic                 overrun_err
);

   localparam logic [ADDRWIDTH:0] LAST_IDX =
      (ADDRWIDTH+1)'(NPIXELS - 1);

   state_t state;
   state_t state_next;

   logic take;
   logic last;
   logic arm;
   logic short_hit;
   logic stray;

   assign take = (state == ST_CAPTURE) && bus.Done_one;
   assign last = take && (pix_count == LAST_IDX);
   assign arm  = (state != ST_CAPTURE) && bus.start;

   // a same-cycle final pixel completes the frame, so no error then
   assign short_hit = (state == ST_CAPTURE)
                    && bus.Done_full && !last;

   assign stray = (state == ST_DONE)
                && bus.Done_one && !bus.start;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: begin
            if (bus.start) state_next = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (last || bus.Done_full) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.start) state_next = ST_CAPTURE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      frame_done = 1'b0;
      unique case (state)
         ST_CAPTURE: busy       = 1'b1;
         ST_DONE:    frame_done = 1'b1;
         default:    ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         bus.wea   <= 1'b0;
         bus.addra <= '0;
         bus.dina  <= '0;
      end else begin
         bus.wea <= take;
         if (take) begin
            bus.addra <= pix_count[ADDRWIDTH-1:0];
            bus.dina  <= bus.Gray;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pix_count <= '0;
         checksum  <= '0;
      end else if (arm) begin
         pix_count <= '0;
         checksum  <= '0;
      end else if (take) begin
         pix_count <= pix_count + 1'b1;
         checksum  <= checksum + SUMWIDTH'(bus.Gray);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST || arm) begin
         short_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         if (short_hit) short_err   <= 1'b1;
         if (stray)     overrun_err <= 1'b1;
      end
   end

endmodule
